// File: rtl/wb_seq_pkg.sv
// Shared types for the Wishbone trigger sequencer (wb_seq_master and its timer).
package wb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    GAP     = 3'd5
  } seq_state_t;

  localparam int STATUS_BITS = 4;

  typedef logic [31:0] wb_word_t;

endpackage

// File: rtl/wb_seq_timer.sv
// Clearable up-counter; tc_o fires on a counting cycle whose count equals limit_i.
module wb_seq_timer
  import wb_seq_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && (cnt_q == limit_i);

endmodule

// File: rtl/wb_seq_master.sv
// Single-outstanding pipelined Wishbone master turning trigger pulses into control writes.
// Define SEQ_POLL_EN to poll the slave status word until idle before the next write.
module wb_seq_master
  import wb_seq_pkg::*;
#(
  parameter wb_word_t TARGET_ADDR = 32'h0000_0000,
  parameter wb_word_t WRITE_DATA  = 32'h0000_0001,
  parameter int       MAX_PENDING = 7,
  parameter int       ACK_TIMEOUT = 16,
  parameter int       POLL_GAP    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               trigger,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               done,
  output logic                               err,
  output logic                               ovf,
  output wb_word_t                           wb_addr,
  output wb_word_t                           wb_data_w,
  input  wb_word_t                           wb_data_r,
  output logic                               wb_we,
  output logic                               wb_stb,
  output logic                               wb_cyc,
  input  logic                               wb_ack,
  input  logic                               wb_stall,
  output logic [2:0]                         state_dbg
);

  localparam int PW   = $clog2(MAX_PENDING + 1);
  localparam int TMAX = (ACK_TIMEOUT > POLL_GAP) ? ACK_TIMEOUT : POLL_GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  seq_state_t    state_q, state_d;
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic          done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          abort, retire;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_limit;
  logic          unused_rdata;

  // Handshake: stb is valid, !wb_stall is ready; a transfer is accepted on an
  // edge where stb && !wb_stall, and its single ack arrives in a later cycle.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    abort   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = WR_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
        end
      end
      WR_REQ: begin
        if (tmr_tc) begin
          abort = 1'b1;
        end else if (!wb_stall) begin
          state_d = WR_WAIT;
          stb_d   = 1'b0;
          we_d    = 1'b0;
        end
      end
      WR_WAIT: begin
        if (wb_ack) begin
          cyc_d = 1'b0;
`ifdef SEQ_POLL_EN
          state_d = RD_REQ;
`else
          state_d = IDLE;
          done_d  = 1'b1;
          retire  = 1'b1;
`endif
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
`ifdef SEQ_POLL_EN
      RD_REQ: begin
        // Entered with cyc low after a write so the bus idles one cycle first.
        if (!cyc_q) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
        end else if (tmr_tc) begin
          abort = 1'b1;
        end else if (!wb_stall) begin
          state_d = RD_WAIT;
          stb_d   = 1'b0;
        end
      end
      RD_WAIT: begin
        if (wb_ack) begin
          cyc_d = 1'b0;
          if (wb_data_r[STATUS_BITS-1:0] == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            retire  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else if (tmr_tc) begin
          abort = 1'b1;
        end
      end
      GAP: begin
        if (tmr_tc) begin
          state_d = RD_REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      we_d    = 1'b0;
      err_d   = 1'b1;
      retire  = 1'b1;
    end

    // A trigger coinciding with a retirement cancels out, even when full.
    if (trigger && !retire) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (retire && !trigger) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  // One timer serves both the ack timeout (counted only while cyc is high) and GAP.
  assign tmr_clr   = (state_d != state_q) && (state_d inside {WR_REQ, RD_REQ, GAP});
  assign tmr_en    = cyc_q || (state_q == GAP);
  assign tmr_limit = (state_q == GAP) ? TW'(POLL_GAP - 1) : TW'(ACK_TIMEOUT - 1);

  wb_seq_timer #(.W(TW)) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  assign unused_rdata = ^wb_data_r;

  assign pending   = pend_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign wb_addr   = TARGET_ADDR;
  assign wb_data_w = WRITE_DATA;
  assign wb_we     = we_q;
  assign wb_stb    = stb_q;
  assign wb_cyc    = cyc_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_wb_seq_master.sv
// Directed bench for wb_seq_master: negedge slave model, cyc-burst scoreboard, final report.
module tb_wb_seq_master;

  localparam logic [31:0] TA = 32'h0000_1230;
  localparam logic [31:0] WD = 32'h0000_00A5;
`ifdef SEQ_POLL_EN
  localparam int DONE_CYC = 7;
`else
  localparam int DONE_CYC = 4;
`endif

  logic        clk, rst, trigger;
  logic [2:0]  pending;
  logic        done, err, ovf;
  logic [31:0] wb_addr, wb_data_w, wb_data_r;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_stall;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // slave model knobs and monitor state
  int  stall_left = 0;
  int  noack_left = 0;
  bit  ack_next   = 0;
  bit  ack_is_rd  = 0;
  bit  stray_ack  = 0;
  int  wr_cnt = 0, rd_cnt = 0, stable_cnt = 0, done_cnt = 0, viol_cnt = 0;
  int  hi_run = 0, low_run = 0, last_gap = 0;
  bit  cyc_prev = 0;
  logic [31:0] status_q[$];
  logic [31:0] exp_q[$];

  int base_done, base_wr, base_rd, n;

  wb_seq_master #(
    .TARGET_ADDR (TA),
    .WRITE_DATA  (WD),
    .MAX_PENDING (7),
    .ACK_TIMEOUT (16),
    .POLL_GAP    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .pending   (pending),
    .done      (done),
    .err       (err),
    .ovf       (ovf),
    .wb_addr   (wb_addr),
    .wb_data_w (wb_data_w),
    .wb_data_r (wb_data_r),
    .wb_we     (wb_we),
    .wb_stb    (wb_stb),
    .wb_cyc    (wb_cyc),
    .wb_ack    (wb_ack),
    .wb_stall  (wb_stall),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Expected cyc bursts for one request whose write burst lasts wlen cycles.
  task automatic push_req(input int wlen);
    exp_q.push_back(32'(wlen));
`ifdef SEQ_POLL_EN
    exp_q.push_back(32'd2);
`endif
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(done_cnt), 32'(target));
  endtask

  // Slave model and bus monitor: drives this cycle's stall/ack and scores cyc bursts.
  always @(negedge clk) begin
    wb_ack = 1'b0;
    if (ack_next) begin
      wb_ack    = 1'b1;
      ack_next  = 1'b0;
      wb_data_r = (ack_is_rd && status_q.size() > 0) ? status_q.pop_front() : 32'h0;
    end
    if (stray_ack) begin
      wb_ack    = 1'b1;
      stray_ack = 1'b0;
    end
    wb_stall = 1'b0;
    if (wb_cyc && wb_stb) begin
      if (stall_left > 0) begin
        wb_stall = 1'b1;
        stall_left--;
        if (wb_we && wb_addr == TA && wb_data_w == WD) stable_cnt++;
      end else begin
        if (wb_we) wr_cnt++;
        else rd_cnt++;
        if (noack_left > 0) begin
          noack_left--;
        end else begin
          ack_next  = 1'b1;
          ack_is_rd = !wb_we;
        end
      end
    end
    if (wb_stb && !wb_cyc) viol_cnt++;
    if (wb_we && !wb_stb) viol_cnt++;
    if (done) done_cnt++;
    if (wb_cyc) begin
      if (!cyc_prev) begin
        last_gap = low_run;
        hi_run   = 0;
      end
      hi_run++;
    end else begin
      if (cyc_prev) begin
        low_run = 0;
        if (exp_q.size() == 0) check_eq("burst_unexpected", 32'(hi_run), 32'd0);
        else check_eq("burst_len", 32'(hi_run), exp_q.pop_front());
      end
      low_run++;
    end
    cyc_prev = wb_cyc;
  end

  initial begin
    rst       = 1'b1;
    trigger   = 1'b0;
    wb_ack    = 1'b0;
    wb_stall  = 1'b0;
    wb_data_r = 32'h0;
    tick(3);
    check_eq("rst_cyc", 32'(wb_cyc), 0);
    check_eq("rst_stb", 32'(wb_stb), 0);
    check_eq("rst_we", 32'(wb_we), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_ovf", 32'(ovf), 0);
    check_eq("rst_pending", 32'(pending), 0);
    check_eq("rst_state", 32'(state_dbg), 0);
    check_eq("addr", wb_addr, TA);
    check_eq("wdata", wb_data_w, WD);
    rst = 1'b0;
    tick(2);

    // single trigger, no stall: latency and one done pulse
    base_done = done_cnt; base_wr = wr_cnt;
    push_req(2);
    trigger = 1'b1; tick(1); trigger = 1'b0;
    check_eq("lat_pending_c1", 32'(pending), 1);
    check_eq("lat_stb_c1", 32'(wb_stb), 0);
    tick(1);
    check_eq("lat_stb_c2", 32'(wb_stb), 1);
    check_eq("lat_we_c2", 32'(wb_we), 1);
    check_eq("lat_cyc_c2", 32'(wb_cyc), 1);
    tick(DONE_CYC - 2);
    check_eq("single_done", 32'(done), 1);
    check_eq("single_pending", 32'(pending), 0);
    tick(1);
    check_eq("single_done_pulse", 32'(done), 0);
    tick(3);
    check_eq("single_done_cnt", 32'(done_cnt - base_done), 1);
    check_eq("single_wr_cnt", 32'(wr_cnt - base_wr), 1);

    // five stalled cycles on the write
    base_done = done_cnt; base_wr = wr_cnt; stable_cnt = 0;
    stall_left = 5;
    push_req(7);
    trigger = 1'b1; tick(1); trigger = 1'b0;
    wait_done("stall_done", base_done + 1, 100);
    tick(2);
    check_eq("stall_stable", 32'(stable_cnt), 5);
    check_eq("stall_wr_cnt", 32'(wr_cnt - base_wr), 1);

    // first write never acked: abort after 16 cyc cycles, queued request still runs
    base_done = done_cnt;
    noack_left = 1;
    exp_q.push_back(32'd16);
    push_req(2);
    trigger = 1'b1; tick(2); trigger = 1'b0;
    tick(15);
    check_eq("to_cyc_last", 32'(wb_cyc), 1);
    check_eq("to_err_before", 32'(err), 0);
    tick(1);
    check_eq("to_cyc_drop", 32'(wb_cyc), 0);
    check_eq("to_err", 32'(err), 1);
    check_eq("to_pending", 32'(pending), 1);
    check_eq("to_no_done", 32'(done), 0);
    wait_done("to_next_done", base_done + 1, 200);
    tick(2);
    check_eq("to_pending_end", 32'(pending), 0);

    // nine back-to-back triggers against a stalled first write
    base_done = done_cnt; base_wr = wr_cnt;
    stall_left = 12;
    push_req(14);
    for (int i = 0; i < 6; i++) push_req(2);
    trigger = 1'b1; tick(7);
    check_eq("sat_pending_c7", 32'(pending), 7);
    check_eq("sat_ovf_c7", 32'(ovf), 0);
    tick(2); trigger = 1'b0; tick(1);
    check_eq("sat_pending", 32'(pending), 7);
    check_eq("sat_ovf", 32'(ovf), 1);
    wait_done("sat_done_cnt", base_done + 7, 600);
    tick(2);
    check_eq("sat_wr_cnt", 32'(wr_cnt - base_wr), 7);
    check_eq("sat_pending_end", 32'(pending), 0);
    check_eq("sat_err_sticky", 32'(err), 1);

    // reset while waiting for an ack, then a late ack
    base_done = done_cnt;
    noack_left = 1;
    exp_q.push_back(32'd4);
    trigger = 1'b1; tick(1); trigger = 1'b0;
    n = 0;
    while (!wb_cyc && n < 10) begin tick(1); n++; end
    check_eq("rmid_started", 32'(wb_cyc), 1);
    tick(3);
    rst = 1'b1; tick(1);
    check_eq("rmid_cyc", 32'(wb_cyc), 0);
    check_eq("rmid_stb", 32'(wb_stb), 0);
    check_eq("rmid_pending", 32'(pending), 0);
    check_eq("rmid_err", 32'(err), 0);
    check_eq("rmid_ovf", 32'(ovf), 0);
    rst = 1'b0;
    stray_ack = 1'b1;
    tick(4);
    check_eq("rmid_no_done", 32'(done_cnt - base_done), 0);
    check_eq("rmid_idle_cyc", 32'(wb_cyc), 0);

`ifdef SEQ_POLL_EN
    // status 3 then 0: one write, two reads, four idle cycles between reads
    base_done = done_cnt; base_wr = wr_cnt; base_rd = rd_cnt;
    status_q.push_back(32'd3);
    status_q.push_back(32'd0);
    exp_q.push_back(32'd2); exp_q.push_back(32'd2); exp_q.push_back(32'd2);
    trigger = 1'b1; tick(1); trigger = 1'b0;
    wait_done("poll_done", base_done + 1, 200);
    tick(2);
    check_eq("poll_wr_cnt", 32'(wr_cnt - base_wr), 1);
    check_eq("poll_rd_cnt", 32'(rd_cnt - base_rd), 2);
    check_eq("poll_gap", 32'(last_gap), 4);
    check_eq("poll_pending", 32'(pending), 0);
`else
    // two triggers: second write one idle cycle after the first ack, no reads
    base_done = done_cnt; base_wr = wr_cnt;
    push_req(2);
    push_req(2);
    trigger = 1'b1; tick(2); trigger = 1'b0;
    wait_done("two_done", base_done + 2, 100);
    tick(2);
    check_eq("two_gap", 32'(last_gap), 1);
    check_eq("two_wr_cnt", 32'(wr_cnt - base_wr), 2);
    check_eq("no_reads", 32'(rd_cnt), 0);
`endif

    tick(5);
    check_eq("sb_empty", 32'(exp_q.size()), 0);
    check_eq("bus_rules", 32'(viol_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_seq_master.md
Name: wb_seq_master

Overview:
- Single-outstanding Wishbone (pipelined) master sitting directly upstream of the LED-animation slave.
- Converts local trigger pulses into write transactions to the slave's control register.
- Optionally polls the slave's status word until the animation finishes before issuing the next write.
- Queues triggers in a saturating pending counter; flags bus timeouts and dropped triggers.

Parameters:
- TARGET_ADDR, 32'h0000_0000, address driven on wb_addr for every cycle.
- WRITE_DATA, 32'h0000_0001, value driven on wb_data_w for writes.
- MAX_PENDING, 7, max queued triggers (pending counter width = $clog2(MAX_PENDING+1)).
- ACK_TIMEOUT, 16, cycles allowed from stb assertion to ack before abort.
- POLL_GAP, 4, idle cycles (cyc low) between consecutive status polls.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- trigger  in  1  one-cycle request pulse; each high cycle counts as one request.
- pending  out  $clog2(MAX_PENDING+1)  queued requests, including the one in flight.
- done  out  1  one-cycle pulse when a request completes successfully.
- err  out  1  sticky: an ack timeout occurred; cleared only by rst.
- ovf  out  1  sticky: a trigger was dropped at pending==MAX_PENDING; cleared only by rst.
- wb_addr  out  32  always TARGET_ADDR.
- wb_data_w  out  32  always WRITE_DATA.
- wb_data_r  in  32  read data; bits [3:0] are slave state, nonzero means busy.
- wb_we  out  1  write enable; valid only while wb_stb.
- wb_stb  out  1  strobe.
- wb_cyc  out  1  bus cycle.
- wb_ack  in  1  transfer acknowledge.
- wb_stall  in  1  slave not accepting this cycle.

Behaviour:
- Reset: cyc, stb, we, done, err, ovf = 0; pending = 0; FSM = IDLE; timers = 0.
- Reset mid-transaction: cyc drops the next cycle; any in-flight ack is ignored.
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, GAP.
- IDLE: when pending>0, go to WR_REQ; cyc=1, stb=1, we=1 in the same registered update.
- WR_REQ: hold stb/we until a cycle with !wb_stall. On that edge drop stb (and we), keep cyc, go to WR_WAIT.
- WR_WAIT: on wb_ack, drop cyc and go to RD_REQ. Without SEQ_POLL_EN, go to IDLE instead and pulse done.
- RD_REQ: cyc=1, stb=1, we=0; accept/ack handling same as writes; ack leads to evaluation of wb_data_r.
- Status evaluation: wb_data_r[3:0]==0 means done pulse, pending decrement, IDLE. Nonzero means GAP.
- GAP: cyc=0 for exactly POLL_GAP cycles, then RD_REQ.
- Bus rules:
  - stb only while cyc; we=0 whenever stb=0.
  - At most one accepted-but-unacked transfer.
  - cyc low for at least one cycle between any two transactions.
  - A stray ack while not waiting is ignored.
- Timeout:
  - A timer clears on entry to WR_REQ/RD_REQ and counts each cycle in REQ/WAIT.
  - On reaching ACK_TIMEOUT without ack: drop cyc/stb, set err, decrement pending (request abandoned), go to IDLE; no done pulse.
- Pending counter:
  - trigger increments it, saturating at MAX_PENDING; a trigger at MAX_PENDING sets ovf.
  - Simultaneous trigger and completion/abandon leaves pending unchanged and does not set ovf, even at MAX_PENDING.
- Latency: trigger in IDLE with zero stall gives stb high at cycle +2 (counter update, then FSM).

Optional Feature:
- Macro SEQ_POLL_EN.
- Defined: the write/poll sequence above; the next write waits until the slave reports idle.
- Undefined: RD_REQ, RD_WAIT and GAP are not built. done pulses on write ack, and the next write issues immediately; the slave's stall provides back-pressure.
- POLL_GAP is unused when undefined.
- ACK_TIMEOUT must exceed the slave's full animation time when undefined, because stall counts toward the timeout.

Decomposition:
- Package wb_seq_pkg holds:
  - enum seq_state_t {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, GAP};
  - localparam STATUS_BITS=4;
  - typedef logic [31:0] wb_word_t.
- Sub-module wb_seq_timer: a clearable up-counter with terminal-count output, used for both the ack timeout and GAP.

Test Plan:
- Single trigger, slave with no stall, ack 1 cycle after accept, status reads 3 then 0: exactly one write then two reads, a 4-cycle cyc-low gap between them, done pulses once, pending returns 0.
- Slave holds wb_stall for 5 cycles during WR_REQ: stb/we/addr/data stay stable all 5 cycles; exactly one write is accepted.
- 9 trigger pulses in 9 consecutive cycles while idle: pending saturates at 7, ovf=1, exactly 7 done pulses follow.
- Slave never acks: cyc drops after 16 cycles, err=1, pending decrements, the next queued request still runs.
- rst asserted while in RD_WAIT: next cycle cyc=stb=0, pending=0, err=ovf=0; a late ack causes no done pulse.
- Without SEQ_POLL_EN, 2 triggers: second write issues right after the first ack; no reads (we=0 with stb never occurs).
